// File: rtl/ysyx_22040175_hazard_ctrl.sv
// ysyx_22040175_hazard_ctrl
// Hazard and redirect controller for a 4- or 5-stage in-order pipeline.
// It tracks in-flight register writers in SLOTS = STAGES-2 slots
// (slot0 = EX ... slot SLOTS-1 = WB). It produces the stall, bubble and flush
// controls, selects the operand forwarding source, and runs a two-state
// redirect handshake towards IF.
//
// Build option: define YSYX_22040175_BYPASS_EN to enable operand bypassing.
// With bypassing, only a load-use in slot0 stalls. Without it, any pending
// writer of a source register stalls ID and fwd_sel stays 0.
//
// STAGES must be 4 or 5, so the 2-bit fwd_sel codes can name every slot.

module ysyx_22040175_hazard_ctrl #(
    parameter int XLEN   = 64,
    parameter int STAGES = 5,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              id_wen,
    input  logic [REG_AW-1:0] id_waddr,
    input  logic              id_is_load,
    input  logic              mem_stall,
    input  logic              ex_redirect_valid,
    input  logic [XLEN-1:0]   ex_redirect_pc,
    input  logic              if_redirect_ack,
    output logic              if_stall,
    output logic              id_ex_bubble,
    output logic              if_id_flush,
    output logic              redirect_req,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [1:0]        fwd_sel_rs1,
    output logic [1:0]        fwd_sel_rs2,
    output logic [31:0]       stall_cnt
);

    localparam int SLOTS = STAGES - 2;

    // One in-flight instruction, reduced to what hazard detection needs.
    typedef struct packed {
        logic              valid;
        logic              wen;
        logic [REG_AW-1:0] waddr;
        logic              is_load;
    } slot_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } redir_state_e;

    slot_t [SLOTS-1:0] slot_q, slot_d;
    redir_state_e      state_q, state_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic [31:0]       stall_cnt_q, stall_cnt_d;

    logic              frozen;
    logic              flush_now;
    logic              hz_stall;
    logic [SLOTS-1:0]  prod_rs1, prod_rs2;
    logic [1:0]        fwd_rs1, fwd_rs2;
    logic              unused_is_load;

    // A slot produces a source only for a real, read, non-x0 register it writes.
    function automatic logic is_producer(input slot_t s, input logic [REG_AW-1:0] src,
                                         input logic used);
        return s.valid && s.wen && (s.waddr == src) && (src != '0) && used;
    endfunction

    assign frozen    = mem_stall;
    assign flush_now = ((state_q == ST_IDLE) && ex_redirect_valid && !frozen)
                     || (state_q == ST_WAIT);

    // Per-slot producer match for each ID source operand.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        prod_rs1 = '0;
        prod_rs2 = '0;
        for (int k = 0; k < SLOTS; k++) begin
            prod_rs1[k] = is_producer(slot_q[k], id_rs1, id_rs1_used);
            prod_rs2[k] = is_producer(slot_q[k], id_rs2, id_rs2_used);
        end
    end

`ifdef YSYX_22040175_BYPASS_EN
    // Youngest usable producer wins. A load in slot0 has no data yet, so it is skipped.
    function automatic logic [1:0] pick_fwd(input logic [SLOTS-1:0] prod,
                                            input logic slot0_load);
        logic [1:0] sel;
        sel = '0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            if (prod[k] && !((k == 0) && slot0_load)) begin
                sel = 2'(k + 1);
            end
        end
        return sel;
    endfunction

    // Only a load-use on the EX slot stalls. Everything else is bypassed.
    always_comb begin
        hz_stall = slot_q[0].is_load && (prod_rs1[0] || prod_rs2[0]);
        fwd_rs1  = pick_fwd(prod_rs1, slot_q[0].is_load);
        fwd_rs2  = pick_fwd(prod_rs2, slot_q[0].is_load);
    end
`else
    // No bypass network: any pending writer of a source stalls ID.
    always_comb begin
        hz_stall = (|prod_rs1) || (|prod_rs2);
        fwd_rs1  = '0;
        fwd_rs2  = '0;
    end
`endif

    // The load flags are read only by the bypass path; fold them so every build uses them.
    always_comb begin
        unused_is_load = 1'b0;
        for (int k = 0; k < SLOTS; k++) begin
            unused_is_load = unused_is_load ^ slot_q[k].is_load;
        end
    end

    // Slot pipeline: shift toward WB; slot0 takes ID or a bubble; hold while frozen.
    always_comb begin
        slot_d = slot_q;
        if (!frozen) begin
            for (int k = SLOTS - 1; k > 0; k--) begin
                slot_d[k] = slot_q[k-1];
            end
            if (id_valid && !hz_stall && !flush_now) begin
                slot_d[0] = '{valid: 1'b1, wen: id_wen, waddr: id_waddr, is_load: id_is_load};
            end else begin
                slot_d[0] = '0;
            end
        end
    end

    // Redirect FSM: latch the target in IDLE, then hold it until IF acknowledges.
    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        if (!frozen) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ex_redirect_valid) begin
                        state_d       = ST_WAIT;
                        redirect_pc_d = ex_redirect_pc;
                    end
                end
                ST_WAIT: begin
                    if (if_redirect_ack) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Count cycles lost to data hazards only, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hz_stall && !flush_now && !frozen && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the slot array is a few flops, not a RAM, so it is reset to clear stale valids.
            slot_q        <= '0;
            state_q       <= ST_IDLE;
            redirect_pc_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            slot_q        <= slot_d;
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    // Outputs are forced to 0 while reset is held, even before the first reset edge.
    assign if_stall     = rst_n && (frozen || (hz_stall && !flush_now));
    assign id_ex_bubble = rst_n && !frozen && (hz_stall || flush_now);
    assign if_id_flush  = rst_n && flush_now;
    assign redirect_req = rst_n && (state_q == ST_WAIT);
    assign redirect_pc  = rst_n ? redirect_pc_q : '0;
    assign fwd_sel_rs1  = rst_n ? fwd_rs1 : 2'b00;
    assign fwd_sel_rs2  = rst_n ? fwd_rs2 : 2'b00;
    assign stall_cnt    = rst_n ? stall_cnt_q : 32'd0;

endmodule

// File: tb/tb_ysyx_22040175_hazard_ctrl.sv
// Self-checking bench for ysyx_22040175_hazard_ctrl.
// The reference model keeps the in-flight instructions as a small array of
// records plus a "redirect waiting" flag. Every cycle, the expected controls
// are derived from these using the hazard rules.

module tb_ysyx_22040175_hazard_ctrl;

    localparam int XLEN   = 64;
    localparam int STAGES = 5;
    localparam int REG_AW = 5;
    localparam int SLOTS  = STAGES - 2;
`ifdef YSYX_22040175_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1, id_rs2;
    logic              id_rs1_used, id_rs2_used;
    logic              id_wen;
    logic [REG_AW-1:0] id_waddr;
    logic              id_is_load;
    logic              mem_stall;
    logic              ex_redirect_valid;
    logic [XLEN-1:0]   ex_redirect_pc;
    logic              if_redirect_ack;
    logic              if_stall, id_ex_bubble, if_id_flush, redirect_req;
    logic [XLEN-1:0]   redirect_pc;
    logic [1:0]        fwd_sel_rs1, fwd_sel_rs2;
    logic [31:0]       stall_cnt;

    ysyx_22040175_hazard_ctrl #(
        .XLEN(XLEN), .STAGES(STAGES), .REG_AW(REG_AW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_wen(id_wen), .id_waddr(id_waddr), .id_is_load(id_is_load),
        .mem_stall(mem_stall),
        .ex_redirect_valid(ex_redirect_valid), .ex_redirect_pc(ex_redirect_pc),
        .if_redirect_ack(if_redirect_ack),
        .if_stall(if_stall), .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
        .redirect_req(redirect_req), .redirect_pc(redirect_pc),
        .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit              valid;
        bit              wen;
        bit              is_load;
        bit [REG_AW-1:0] rd;
    } instr_t;

    instr_t          inflight [SLOTS];
    bit              m_wait;
    logic [XLEN-1:0] m_pc;
    logic [31:0]     m_cnt;

    function automatic bit writes(input instr_t i, input logic [REG_AW-1:0] src, input logic used);
        return i.valid && i.wen && (used === 1'b1) && (src != 0) && (i.rd == src);
    endfunction

    function automatic bit m_hazard();
        bit h = 1'b0;
        for (int k = 0; k < SLOTS; k++) begin
            if (writes(inflight[k], id_rs1, id_rs1_used) || writes(inflight[k], id_rs2, id_rs2_used)) begin
                if (!BYP || (k == 0 && inflight[k].is_load)) h = 1'b1;
            end
        end
        return h;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [REG_AW-1:0] src, input logic used);
        if (!BYP) return 2'd0;
        for (int k = 0; k < SLOTS; k++) begin
            if (writes(inflight[k], src, used) && !(k == 0 && inflight[k].is_load)) return 2'(k + 1);
        end
        return 2'd0;
    endfunction

    // Sampled DUT outputs from the most recent step.
    logic [63:0] obs_if_stall, obs_bubble, obs_flush, obs_req, obs_pc, obs_fwd1, obs_fwd2, obs_cnt;

    // One clock: sample at negedge, compare with the model, advance the model at posedge.
    task automatic step();
        bit hz, fl;
        @(negedge clk);
        obs_if_stall = 64'(if_stall);
        obs_bubble   = 64'(id_ex_bubble);
        obs_flush    = 64'(if_id_flush);
        obs_req      = 64'(redirect_req);
        obs_pc       = 64'(redirect_pc);
        obs_fwd1     = 64'(fwd_sel_rs1);
        obs_fwd2     = 64'(fwd_sel_rs2);
        obs_cnt      = 64'(stall_cnt);
        if (!rst_n) begin
            check("rst_if_stall", obs_if_stall, 64'd0);
            check("rst_bubble",   obs_bubble,   64'd0);
            check("rst_flush",    obs_flush,    64'd0);
            check("rst_req",      obs_req,      64'd0);
            check("rst_pc",       obs_pc,       64'd0);
            check("rst_fwd1",     obs_fwd1,     64'd0);
            check("rst_fwd2",     obs_fwd2,     64'd0);
            check("rst_cnt",      obs_cnt,      64'd0);
            foreach (inflight[k]) inflight[k] = '{default: 0};
            m_wait = 1'b0;
            m_pc   = '0;
            m_cnt  = '0;
        end else begin
            hz = m_hazard();
            fl = m_wait || (ex_redirect_valid && !mem_stall);
            check("if_stall",     obs_if_stall, 64'(mem_stall || (hz && !fl)));
            check("id_ex_bubble", obs_bubble,   64'(!mem_stall && (hz || fl)));
            check("if_id_flush",  obs_flush,    64'(fl));
            check("redirect_req", obs_req,      64'(m_wait));
            check("redirect_pc",  obs_pc,       64'(m_pc));
            check("stall_cnt",    obs_cnt,      64'(m_cnt));
            if (!hz) begin
                check("fwd_sel_rs1", obs_fwd1, 64'(m_fwd(id_rs1, id_rs1_used)));
                check("fwd_sel_rs2", obs_fwd2, 64'(m_fwd(id_rs2, id_rs2_used)));
            end
            if (!mem_stall) begin
                for (int k = SLOTS - 1; k > 0; k--) inflight[k] = inflight[k-1];
                if (id_valid && !hz && !fl)
                    inflight[0] = '{valid: 1'b1, wen: id_wen, is_load: id_is_load, rd: id_waddr};
                else
                    inflight[0] = '{default: 0};
                if (hz && !fl && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                if (!m_wait) begin
                    if (ex_redirect_valid) begin
                        m_wait = 1'b1;
                        m_pc   = ex_redirect_pc;
                    end
                end else if (if_redirect_ack) begin
                    m_wait = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [REG_AW-1:0] r1, input logic u1,
                          input logic [REG_AW-1:0] r2, input logic u2,
                          input logic w, input logic [REG_AW-1:0] wa, input logic ld);
        id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
        id_wen = w; id_waddr = wa; id_is_load = ld;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        mem_stall = 1'b0; ex_redirect_valid = 1'b0; if_redirect_ack = 1'b0;
    endtask

    logic [63:0] cnt0;
    int          n_stall;
    bit          done;

    initial begin
        rst_n = 1'b0;
        ex_redirect_pc = '0;
        idle();
        step();
        mem_stall = 1'b1; ex_redirect_valid = 1'b1;
        step();
        check("reset_if_stall_gated", obs_if_stall, 64'd0);
        rst_n = 1'b1;
        idle();
        step();
        check("reset_cnt_zero", obs_cnt, 64'd0);

        // Simple ALU producer of x5 in EX, then a consumer of x5.
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
        step();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        step();
        check("alu_stall_c1", obs_if_stall, 64'(!BYP));
        check("alu_fwd_c1",   obs_fwd1,     BYP ? 64'd1 : 64'd0);
        step();
        check("alu_stall_c2", obs_if_stall, 64'(!BYP));
        step();
        check("alu_stall_c3", obs_if_stall, 64'(!BYP));
        step();
        check("alu_stall_c4", obs_if_stall, 64'd0);
        idle();
        step();
        check("alu_cnt", obs_cnt, BYP ? 64'd0 : 64'd3);
        repeat (3) step();

        // Load x7 in EX, then a consumer of x7.
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1);
        step();
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        step();
        check("lu_stall_c1",  obs_if_stall, 64'd1);
        check("lu_bubble_c1", obs_bubble,   64'd1);
        step();
        check("lu_stall_c2",  obs_if_stall, 64'(!BYP));
        check("lu_bubble_c2", obs_bubble,   64'(!BYP));
        check("lu_fwd_c2",    obs_fwd1,     BYP ? 64'd2 : 64'd0);
        idle();
        repeat (4) step();

        // Redirect with the ack two cycles after the request.
        ex_redirect_valid = 1'b1; ex_redirect_pc = 64'h0000_0000_8000_0040;
        step();
        check("rd_flush_c1", obs_flush, 64'd1);
        check("rd_req_c1",   obs_req,   64'd0);
        ex_redirect_pc = 64'hDEAD_BEEF_0000_0000;
        step();
        check("rd_flush_c2", obs_flush, 64'd1);
        check("rd_req_c2",   obs_req,   64'd1);
        check("rd_pc_c2",    obs_pc,    64'h0000_0000_8000_0040);
        if_redirect_ack = 1'b1;
        step();
        check("rd_flush_c3", obs_flush, 64'd1);
        check("rd_req_c3",   obs_req,   64'd1);
        check("rd_pc_c3",    obs_pc,    64'h0000_0000_8000_0040);
        if_redirect_ack = 1'b0; ex_redirect_valid = 1'b0;
        step();
        check("rd_flush_c4", obs_flush, 64'd0);
        check("rd_req_c4",   obs_req,   64'd0);
        if_redirect_ack = 1'b1;
        step();
        if_redirect_ack = 1'b0;
        step();
        check("rd_idle_ack_ignored", obs_req, 64'd0);

        // Redirect and load-use hazard in the same cycle.
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1);
        step();
        cnt0 = obs_cnt;
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        ex_redirect_valid = 1'b1; ex_redirect_pc = 64'h0000_0000_0000_1000;
        step();
        check("prio_if_stall", obs_if_stall, 64'd0);
        check("prio_bubble",   obs_bubble,   64'd1);
        idle();
        if_redirect_ack = 1'b1;
        step();
        check("prio_cnt", obs_cnt, cnt0);
        idle();
        repeat (4) step();

        // mem_stall for four cycles while a load-use hazard is pending.
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1);
        step();
        cnt0 = obs_cnt;
        set_id(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0);
        mem_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("frz_if_stall", obs_if_stall, 64'd1);
            check("frz_bubble",   obs_bubble,   64'd0);
            check("frz_cnt",      obs_cnt,      cnt0);
        end
        mem_stall = 1'b0;
        step();
        check("frz_release_stall", obs_if_stall, 64'd1);
        n_stall = 1;
        done = 1'b0;
        for (int i = 0; i < 6 && !done; i++) begin
            step();
            if (obs_if_stall == 64'd1) n_stall++;
            else done = 1'b1;
        end
        check("frz_stall_len", 64'(n_stall), BYP ? 64'd1 : 64'd3);
        check("frz_cnt_after", obs_cnt, cnt0 + (BYP ? 64'd1 : 64'd3));
        check("frz_fwd2", obs_fwd2, BYP ? 64'd2 : 64'd0);
        idle();
        repeat (4) step();

        // x0 is never a dependency.
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1);
        step();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        step();
        check("x0_stall",  obs_if_stall, 64'd0);
        check("x0_bubble", obs_bubble,   64'd0);

        // Reset while waiting for the redirect ack.
        idle();
        ex_redirect_valid = 1'b1; ex_redirect_pc = 64'h0000_0000_0000_2000;
        step();
        ex_redirect_valid = 1'b0;
        step();
        check("rw_req_before", obs_req, 64'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("rw_req_after", obs_req, 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst_n             = ($urandom_range(0, 99) != 0);
            mem_stall         = ($urandom_range(0, 4) == 0);
            ex_redirect_valid = ($urandom_range(0, 7) == 0);
            ex_redirect_pc    = {$urandom, $urandom};
            if_redirect_ack   = ($urandom_range(0, 2) == 0);
            set_id(1'($urandom_range(0, 3) != 0),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 2) == 0));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
